sid_top: RTL and testbench

//  Single SID-style voice: 24-bit phase accumulator, waveform generator, ADSR envelope and

---
 rtl/sid_top.sv | 195 +++++++++++++++++++
 tb/tb_sid_top.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sid_top.sv
// Single SID-style voice: phase accumulator, waveform mixer, ADSR envelope and
// 9-clk shift-add amplitude multiplier. Define NOISE_EN to build the LFSR noise source.
module sid_top #(
    parameter int RATE_SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] frequency,
    input  logic [7:0]  duration,
    input  logic [7:0]  attack,
    input  logic [7:0]  sustain,
    input  logic [7:0]  waveform,
    output logic [7:0]  audio_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_ATTACK, S_DECAY, S_SUSTAIN, S_RELEASE
    } env_state_e;

    logic        gate, test;
    logic [23:0] acc_q, acc_d;
    logic [7:0]  saw_w, tri_w, pulse_w, wave;
    logic        any_sel;

    env_state_e  state_q, state_d;
    logic        gate_q;
    logic        gate_rise, gate_fall;
    logic [7:0]  env_q, env_d;
    logic [7:0]  sus_lvl;
    logic [19:0] presc_q, presc_d;
    logic [3:0]  rate;
    logic [19:0] period_m1;
    logic        tick;

    logic [3:0]  frame_q, frame_d;
    logic [7:0]  wave_l_q, wave_l_d;
    logic [7:0]  env_l_q, env_l_d;
    logic [15:0] prod_q, prod_d;
    logic [15:0] addend;
    logic [2:0]  bit_idx;
    logic [7:0]  audio_q, audio_d;

    assign gate      = waveform[0];
    assign test      = waveform[3];
    assign gate_rise = gate & ~gate_q;
    assign gate_fall = ~gate & gate_q;
    assign sus_lvl   = {sustain[3:0], sustain[3:0]};
    assign acc_d     = test ? 24'd0 : acc_q + {8'd0, frequency};

`ifdef NOISE_EN
    logic [22:0] lfsr_q, lfsr_d;
    logic        acc19_q;
    logic [7:0]  noise_w;
    logic        unused;

    assign unused  = ^waveform[2:1];
    assign noise_w = {lfsr_q[22], lfsr_q[20], lfsr_q[16], lfsr_q[13],
                      lfsr_q[11], lfsr_q[7],  lfsr_q[4],  lfsr_q[2]};

    always_comb begin
        lfsr_d = lfsr_q;
        if (test)
            lfsr_d = 23'h7FFFF8;
        else if (acc_q[19] && !acc19_q)
            lfsr_d = {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= 23'h7FFFF8;
            acc19_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            acc19_q <= acc_q[19];
        end
    end
`else
    logic unused;
    assign unused = ^{waveform[7], waveform[2:1]};
`endif

    // Selected waveforms combine by AND; an empty selection is silence.
    always_comb begin
        saw_w   = acc_q[23:16];
        tri_w   = acc_q[23] ? ~acc_q[22:15] : acc_q[22:15];
        pulse_w = (acc_q[23:16] >= duration) ? 8'hFF : 8'h00;
        wave    = 8'hFF;
        any_sel = 1'b0;
        if (waveform[4]) begin wave = wave & tri_w;   any_sel = 1'b1; end
        if (waveform[5]) begin wave = wave & saw_w;   any_sel = 1'b1; end
        if (waveform[6]) begin wave = wave & pulse_w; any_sel = 1'b1; end
`ifdef NOISE_EN
        if (waveform[7]) begin wave = wave & noise_w; any_sel = 1'b1; end
`endif
        if (!any_sel) wave = 8'h00;
    end

    always_comb begin
        case (state_q)
            S_ATTACK:  rate = attack[3:0];
            S_DECAY:   rate = attack[7:4];
            S_RELEASE: rate = sustain[7:4];
            default:   rate = 4'd0;
        endcase
    end

    // >= rather than == so a live rate change never strands the prescaler past its period.
    assign period_m1 = ((20'd1 << rate) << RATE_SHIFT) - 20'd1;
    assign tick      = (presc_q >= period_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (gate_fall)
            state_d = S_RELEASE;
        else if (gate_rise)
            state_d = S_ATTACK;
        else begin
            case (state_q)
                S_ATTACK:  if (env_q == 8'hFF) state_d = S_DECAY;
                S_DECAY:   if (env_q <= sus_lvl) state_d = S_SUSTAIN;
                S_RELEASE: if (env_q == 8'h00) state_d = S_IDLE;
                default:   ;
            endcase
        end
    end

    always_comb begin
        env_d   = env_q;
        presc_d = presc_q + 20'd1;
        if (state_d != state_q) begin
            presc_d = 20'd0;
        end else begin
            if (tick) presc_d = 20'd0;
            case (state_q)
                S_ATTACK:  if (tick && env_q != 8'hFF) env_d = env_q + 8'd1;
                S_DECAY:   if (tick && env_q > sus_lvl) env_d = env_q - 8'd1;
                S_SUSTAIN: env_d = sus_lvl;
                S_RELEASE: if (tick && env_q != 8'h00) env_d = env_q - 8'd1;
                default:   ;
            endcase
        end
    end

    // Frame 0 latches operands; frames 1..8 add wave<<(frame-1) for each env bit.
    assign bit_idx = 3'(frame_q - 4'd1);
    assign addend  = env_l_q[bit_idx] ? ({8'd0, wave_l_q} << bit_idx) : 16'd0;

    always_comb begin
        frame_d  = (frame_q == 4'd8) ? 4'd0 : frame_q + 4'd1;
        wave_l_d = wave_l_q;
        env_l_d  = env_l_q;
        prod_d   = prod_q;
        audio_d  = audio_q;
        if (frame_q == 4'd0) begin
            wave_l_d = wave;
            env_l_d  = env_q;
            prod_d   = 16'd0;
        end else begin
            prod_d = prod_q + addend;
            if (frame_q == 4'd8) audio_d = prod_d[15:8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= 24'd0;
            gate_q   <= 1'b0;
            env_q    <= 8'd0;
            presc_q  <= 20'd0;
            frame_q  <= 4'd0;
            wave_l_q <= 8'd0;
            env_l_q  <= 8'd0;
            prod_q   <= 16'd0;
            audio_q  <= 8'd0;
        end else begin
            acc_q    <= acc_d;
            gate_q   <= gate;
            env_q    <= env_d;
            presc_q  <= presc_d;
            frame_q  <= frame_d;
            wave_l_q <= wave_l_d;
            env_l_q  <= env_l_d;
            prod_q   <= prod_d;
            audio_q  <= audio_d;
        end
    end

    assign audio_out = audio_q;

endmodule

// File: tb/tb_sid_top.sv
// Directed bench for sid_top (default build, NOISE_EN undefined): waveform/amplitude
// table with a settled sustain envelope, plus envelope, TEST and reset sequences.
module tb_sid_top;

    localparam logic [7:0] GATE = 8'h01;
    localparam logic [7:0] TEST = 8'h08;
    localparam logic [7:0] TRI  = 8'h10;
    localparam logic [7:0] SAW  = 8'h20;
    localparam logic [7:0] PUL  = 8'h40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] frequency;
    logic [7:0]  duration, attack, sustain, waveform;
    logic [7:0]  audio_out;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] acc_hi;
        logic [7:0] dur;
        logic [7:0] wsel;
        logic [3:0] sus;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[18];

    sid_top dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frequency (frequency),
        .duration  (duration),
        .attack    (attack),
        .sustain   (sustain),
        .waveform  (waveform),
        .audio_out (audio_out)
    );

    always #10 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: audio_out=%02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic check_rng(input string nm, input logic [7:0] act,
                             input logic [7:0] lo, input logic [7:0] hi);
        n_chk++;
        if ($isunknown(act) || act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: audio_out=%02h expected %02h..%02h", nm, act, lo, hi);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Zero the accumulator with TEST, then step it to exactly {a,16'h0} and freeze it.
    task automatic set_acc(input logic [7:0] a, input logic [7:0] w);
        @(posedge clk); #1;
        frequency = 16'h0000;
        waveform  = TEST | GATE;
        @(posedge clk); #1;
        waveform  = w | GATE;
        frequency = 16'h8000;
        repeat (2 * int'(a)) @(posedge clk);
        #1 frequency = 16'h0000;
    endtask

    initial begin
        //           acc   dur    wave         S     exp
        vecs[0]  = '{8'h80, 8'h00, SAW,        4'hF, 8'h7F};
        vecs[1]  = '{8'hFF, 8'h00, SAW,        4'hF, 8'hFE};
        vecs[2]  = '{8'hFF, 8'h00, SAW,        4'h8, 8'h87};
        vecs[3]  = '{8'h40, 8'h00, TRI,        4'hF, 8'h7F};
        vecs[4]  = '{8'hC0, 8'h00, TRI,        4'hF, 8'h7E};
        vecs[5]  = '{8'h7F, 8'h00, TRI,        4'hF, 8'hFD};
        vecs[6]  = '{8'h80, 8'h80, PUL,        4'hF, 8'hFE};
        vecs[7]  = '{8'h7F, 8'h80, PUL,        4'hF, 8'h00};
        vecs[8]  = '{8'h00, 8'h00, PUL,        4'hF, 8'hFE};
        vecs[9]  = '{8'hFE, 8'hFF, PUL,        4'hF, 8'h00};
        vecs[10] = '{8'hFF, 8'hFF, PUL,        4'hF, 8'hFE};
        vecs[11] = '{8'h90, 8'h80, SAW | PUL,  4'hF, 8'h8F};
        vecs[12] = '{8'h60, 8'h00, SAW | TRI,  4'hF, 8'h3F};
        vecs[13] = '{8'hFF, 8'h00, 8'h00,      4'hF, 8'h00};
        vecs[14] = '{8'hFF, 8'h00, 8'h86,      4'hF, 8'h00};
        vecs[15] = '{8'hFF, 8'h00, SAW,        4'h0, 8'h00};
        vecs[16] = '{8'hFF, 8'h00, SAW,        4'h1, 8'h10};
        vecs[17] = '{8'h01, 8'h00, SAW,        4'hF, 8'h00};

        rst_n = 1'b0; frequency = '0; duration = '0; attack = '0; sustain = '0; waveform = '0;
        cycles(3);
        check("reset_hold", audio_out, 8'h00);
        rst_n = 1'b1;
        cycles(20);
        check("idle_after_reset", audio_out, 8'h00);
        frequency = 16'd148; waveform = SAW;
        cycles(60);
        check("gate_low_silent", audio_out, 8'h00);

        // Attack/decay at rate 0 settle into sustain well within 600 clk.
        frequency = '0; attack = 8'h00; sustain = 8'h0F; waveform = SAW | GATE;
        cycles(600);

        for (int i = 0; i < 18; i++) begin
            sustain  = {4'h0, vecs[i].sus};
            duration = vecs[i].dur;
            set_acc(vecs[i].acc_hi, vecs[i].wsel);
            cycles(20);
            check($sformatf("vec%0d", i), audio_out, vecs[i].exp);
        end

        // Release at rate 0: falls from FF to silence within 300 clk.
        sustain = 8'h0F; duration = 8'h00;
        set_acc(8'hFF, SAW);
        cycles(20);
        check("pre_release", audio_out, 8'hFE);
        waveform = SAW;
        cycles(15);
        check_rng("release_early", audio_out, 8'hD0, 8'hFD);
        cycles(300);
        check("release_done", audio_out, 8'h00);

        // Retrigger during a slow release keeps the current level.
        waveform = SAW | GATE;
        cycles(300);
        check("reattack_full", audio_out, 8'hFE);
        sustain = 8'h4F;
        waveform = SAW;
        cycles(160);
        attack = 8'h0F;
        waveform = SAW | GATE;
        cycles(40);
        check_rng("retrig_no_reset", audio_out, 8'hF1, 8'hF6);
        cycles(200);
        check_rng("retrig_slow_hold", audio_out, 8'hF1, 8'hF6);
        attack = 8'h00;
        cycles(300);
        check("retrig_finish", audio_out, 8'hFE);

        // Attack rate 3: 8 clk per step, FF after 2040 clk.
        sustain = 8'h0F;
        waveform = SAW;
        cycles(300);
        check("idle_before_attack3", audio_out, 8'h00);
        attack = 8'h03;
        waveform = SAW | GATE;
        cycles(1000);
        check_rng("attack3_mid", audio_out, 8'h70, 8'h85);
        cycles(1200);
        check("attack3_full", audio_out, 8'hFE);

        // TEST holds the accumulator at 0; release resumes the ramp from 0.
        attack = 8'h00;
        @(posedge clk); #1;
        frequency = 16'h1000; waveform = TEST | SAW | GATE;
        cycles(40);
        check("test_hold", audio_out, 8'h00);
        @(posedge clk); #1;
        waveform = SAW | GATE;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check_rng("test_resume", audio_out, 8'h03, 8'h06);

        // Asynchronous reset mid-frame clears the output without a clock edge.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", audio_out, 8'h00);
        waveform = '0; frequency = '0;
        cycles(2);
        rst_n = 1'b1;
        cycles(30);
        check("post_reset_idle", audio_out, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
